// File: rtl/uart_pkg.sv
// Shared types and constants for the 8N1 serial receiver.
package uart_pkg;

  localparam int UART_DATA_BITS = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    CLEANUP
  } uart_state_e;

  // Counter value at the middle of a bit period; used to centre the start-bit sample.
  function automatic int unsigned mid_bit_count(input int unsigned clks_per_bit);
    return (clks_per_bit - 1) / 2;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Single-bit two-flop synchronizer with a selectable reset value.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  // NOTE: sequential state uses non-blocking assignments so both flops sample
  // their inputs from the same edge; blocking here would collapse the chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_serial_rx.sv
// 8N1 UART receiver: start, 8 data bits LSB first, stop; one-cycle valid strobe.
// Define UART_RX_FRAME_CHECK_EN to drop frames whose stop bit samples low.
module uart_serial_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 8
) (
  input  logic                      i_Clock,
  input  logic                      i_Rst_L,
  input  logic                      i_RX_Serial,
  output logic                      o_RX_DV,
  output logic [UART_DATA_BITS-1:0] o_RX_Byte
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = $clog2(UART_DATA_BITS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(mid_bit_count(CLKS_PER_BIT));
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(UART_DATA_BITS - 1);

  logic rx_s;

  uart_state_e               state_q, state_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [IDX_W-1:0]          idx_q, idx_d;
  logic [UART_DATA_BITS-1:0] shift_q, shift_d;
  logic [UART_DATA_BITS-1:0] byte_q, byte_d;
  logic                      dv_q, dv_d;

  sync_2ff #(
    .RESET_VAL (1'b1)
  ) u_sync (
    .clk   (i_Clock),
    .rst_n (i_Rst_L),
    .d     (i_RX_Serial),
    .q     (rx_s)
  );

  // NOTE: every output of this block gets a default before the case so no
  // path leaves a signal unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CNT_W'(1);
    idx_d   = idx_q;
    shift_d = shift_q;
    byte_d  = byte_q;
    dv_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (!rx_s) state_d = START;
      end
      START: begin
        if (cnt_q == CNT_MID) begin
          cnt_d   = '0;
          idx_d   = '0;
          state_d = rx_s ? IDLE : DATA;  // high at mid-start is a glitch
        end
      end
      DATA: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d          = '0;
          shift_d[idx_q] = rx_s;
          if (idx_q == IDX_LAST) state_d = STOP;
          else                   idx_d   = idx_q + IDX_W'(1);
        end
      end
      STOP: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = CLEANUP;
`ifdef UART_RX_FRAME_CHECK_EN
          if (rx_s) begin
            byte_d = shift_q;
            dv_d   = 1'b1;
          end
`else
          byte_d = shift_q;
          dv_d   = 1'b1;
`endif
        end
      end
      CLEANUP: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_Clock or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      byte_q  <= '0;
      dv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      byte_q  <= byte_d;
      dv_q    <= dv_d;
    end
  end

  assign o_RX_DV   = dv_q;
  assign o_RX_Byte = byte_q;

endmodule

// File: tb/tb_uart_serial_rx.sv
// Directed bench for uart_serial_rx at 8 clocks per bit.
module tb_uart_serial_rx;

  localparam int CLKS = 8;
  // 2 sync flops + IDLE->START hop + mid-start count + register, then 9 bit periods.
  localparam int DV_LATENCY = 3 + (CLKS - 1) / 2 + 1 + 9 * CLKS;

  logic       clk;
  logic       rst_n;
  logic       rx_serial;
  logic       rx_dv;
  logic [7:0] rx_byte;

  int checks   = 0;
  int failures = 0;

  int         cyc            = 0;
  int         dv_count       = 0;
  int         last_dv_cyc    = 0;
  int         consec_err     = 0;
  int         byte_chg_err   = 0;
  logic       dv_prev        = 1'b0;
  logic [7:0] byte_prev      = 8'h00;
  logic [7:0] got_bytes[$];

  uart_serial_rx #(
    .CLKS_PER_BIT (CLKS)
  ) dut (
    .i_Clock     (clk),
    .i_Rst_L     (rst_n),
    .i_RX_Serial (rx_serial),
    .o_RX_DV     (rx_dv),
    .o_RX_Byte   (rx_byte)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Strobe monitor, sampled 2 ns after each rising edge.
  always @(posedge clk) begin
    #2;
    if (rst_n) begin
      if (rx_dv) begin
        dv_count++;
        last_dv_cyc = cyc;
        got_bytes.push_back(rx_byte);
      end
      if (rx_dv && dv_prev) consec_err++;
      if (!rx_dv && rx_byte !== byte_prev) byte_chg_err++;
    end
    dv_prev   = rx_dv;
    byte_prev = rx_byte;
  end

  task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive_bit(input logic val);
    rx_serial = val;
    wait_cycles(CLKS);
  endtask

  task automatic send_frame(input logic [7:0] data, input logic stop_bit);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(data[i]);
    drive_bit(stop_bit);
    rx_serial = 1'b1;
  endtask

  function automatic logic [31:0] byte_at(input int i);
    if (i < got_bytes.size()) return {24'h0, got_bytes[i]};
    return 32'hDEAD_BEEF;
  endfunction

  initial begin
    int t0;
    int base;
    logic [7:0] partial;

    rst_n     = 1'b0;
    rx_serial = 1'b1;
    wait_cycles(4);
    check("rst_dv", {31'h0, rx_dv}, 32'h0);
    check("rst_byte", {24'h0, rx_byte}, 32'h00);
    rst_n = 1'b1;

    wait_cycles(100);
    check("idle_no_dv", dv_count, 0);

    // Single frame with latency measurement.
    t0 = cyc;
    send_frame(8'hA5, 1'b1);
    wait_cycles(20);
    check("a5_count", dv_count, 1);
    check("a5_byte", byte_at(0), 32'hA5);
    check("a5_latency", last_dv_cyc - t0, DV_LATENCY);

    // Back-to-back frames with no idle gap.
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    send_frame(8'h3C, 1'b1);
    wait_cycles(20);
    check("b2b_count", dv_count, 4);
    check("b2b_byte0", byte_at(1), 32'h00);
    check("b2b_byte1", byte_at(2), 32'hFF);
    check("b2b_byte2", byte_at(3), 32'h3C);
    check("b2b_out", {24'h0, rx_byte}, 32'h3C);

    // Two-cycle low glitch, then a real frame to show the FSM went back to IDLE.
    rx_serial = 1'b0;
    wait_cycles(2);
    rx_serial = 1'b1;
    wait_cycles(30);
    check("glitch_count", dv_count, 4);
    check("glitch_byte", {24'h0, rx_byte}, 32'h3C);
    send_frame(8'h11, 1'b1);
    wait_cycles(20);
    check("post_glitch_count", dv_count, 5);
    check("post_glitch_byte", {24'h0, rx_byte}, 32'h11);

    // Framing error: stop bit low.
    send_frame(8'h81, 1'b0);
    wait_cycles(30);
`ifdef UART_RX_FRAME_CHECK_EN
    check("frame_err_count", dv_count, 5);
    check("frame_err_byte", {24'h0, rx_byte}, 32'h11);
`else
    check("frame_err_count", dv_count, 6);
    check("frame_err_byte", {24'h0, rx_byte}, 32'h81);
`endif

    // Reset during data bit 4 of 8'h5A.
    base    = dv_count;
    partial = 8'h5A;
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(partial[i]);
    rx_serial = partial[4];
    wait_cycles(CLKS / 2);
    rst_n = 1'b0;
    wait_cycles(3);
    check("midrst_dv", {31'h0, rx_dv}, 32'h0);
    check("midrst_byte", {24'h0, rx_byte}, 32'h00);
    rx_serial = 1'b1;
    rst_n     = 1'b1;
    wait_cycles(20);
    check("midrst_no_dv", dv_count - base, 0);
    send_frame(8'hC3, 1'b1);
    wait_cycles(20);
    check("after_rst_count", dv_count - base, 1);
    check("after_rst_byte", {24'h0, rx_byte}, 32'hC3);

    check("dv_single_cycle", consec_err, 0);
    check("byte_held", byte_chg_err, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_serial_rx.md
Name: uart_serial_rx

Overview:
- Asynchronous serial receiver: 8N1 frame (1 start, 8 data LSB-first, 1 stop), no parity.
- Sits at the front of the transceiver chain. Converts the board serial input into a byte plus a one-cycle valid strobe.
- The strobe feeds the encoder path and also triggers the UART transmitter.

Parameters:
- CLKS_PER_BIT, 8, clock cycles per bit period; integer ≥ 4. System default is 1_000_000/115_200 = 8.

Ports:
- i_Clock  input  1  system clock, rising-edge.
- i_Rst_L  input  1  asynchronous active-low reset.
- i_RX_Serial  input  1  serial line; idles high; asynchronous to i_Clock.
- o_RX_DV  output  1  one-cycle strobe: o_RX_Byte holds a newly received byte.
- o_RX_Byte  output  8  last received byte.

Behaviour:
- Clock and reset: one clock, i_Clock. Reset i_Rst_L is asynchronous, active-low.
- Reset values:
  - o_RX_DV=0, o_RX_Byte=8'h00.
  - FSM=IDLE, bit counter=0, bit index=0.
  - Synchronizer flops=1 (idle line).
- Input sync: i_RX_Serial passes through a 2-flop synchronizer. rx_s is the second flop. All decisions use rx_s only.
- Cycle counter: counts 0..CLKS_PER_BIT-1 and is cleared on every state change.
- FSM states: IDLE, START, DATA, STOP, CLEANUP.
  - IDLE: counter held at 0. rx_s==0 → START.
  - START: when counter==(CLKS_PER_BIT-1)/2 (integer division), sample rx_s.
    - 0 → DATA, counter=0, index=0.
    - 1 → IDLE. This is a glitch; no output change.
  - DATA: when counter==CLKS_PER_BIT-1, shift rx_s into internal shift register bit[index] (LSB first), counter=0.
    - index<7 → index+1, stay in DATA.
    - index==7 → STOP.
  - STOP: when counter==CLKS_PER_BIT-1, sample the stop bit.
    - o_RX_Byte ← shift register.
    - o_RX_DV=1 for exactly that next cycle.
    - → CLEANUP.
  - CLEANUP: one cycle, o_RX_DV returns to 0, → IDLE.
- Sample points: every bit is sampled mid-bit. Data bit k is sampled (k+1)*CLKS_PER_BIT cycles after the start-bit sample. The stop bit is sampled 9*CLKS_PER_BIT cycles after it.
- Output stability: o_RX_Byte changes only at the stop-bit sample and is otherwise held, so it is stable between strobes. o_RX_DV is never high for two consecutive cycles.
- Back-to-back frames: a start bit immediately following the stop bit is received correctly. IDLE is re-entered within 2 cycles after the stop-bit sample, i.e. before mid-stop + CLKS_PER_BIT/2.
- Line held low continuously (break): each frame completes. Its stop bit reads 0, so the framing rule below applies. The receiver then restarts and re-detects start.
- Reset mid-frame: immediately returns all state and outputs to reset values. The partial byte is discarded and no strobe is issued.

Optional Feature:
- Macro: UART_RX_FRAME_CHECK_EN.
- Defined: if the stop-bit sample is 0, o_RX_Byte is NOT updated and o_RX_DV stays 0. The FSM still passes through CLEANUP to IDLE.
- Undefined: the stop-bit value is ignored. Byte update and strobe always occur.

Decomposition:
- Package uart_pkg:
  - state enum (IDLE, START, DATA, STOP, CLEANUP);
  - UART_DATA_BITS=8;
  - function computing the mid-bit count (CLKS_PER_BIT-1)/2.
- One natural sub-module: sync_2ff. 1-bit two-flop synchronizer with async active-low reset and parameterised reset value (1 here).

Test Plan:
- Reset → o_RX_DV=0, o_RX_Byte=8'h00. Line held high for 100 cycles → no strobe.
- Send 8'hA5 at CLKS_PER_BIT=8 (bit period = 8 cycles).
  - Exactly one o_RX_DV pulse, 1 cycle wide, o_RX_Byte=8'hA5.
  - Pulse occurs 1 cycle after the stop mid-sample.
- Back-to-back 8'h00, 8'hFF, 8'h3C with no idle gap → three strobes with those bytes in order. o_RX_Byte is held between strobes.
- Low glitch of 2 cycles on an idle line → FSM returns to IDLE, no strobe, o_RX_Byte unchanged.
- Frame 8'h81 with stop bit 0:
  - Macro defined: no strobe, byte unchanged.
  - Macro undefined: strobe with 8'h81.
- Assert i_Rst_L low during data bit 4 of 8'h5A, release, then send 8'hC3 → only one strobe, byte 8'hC3.
